// File: rtl/mux_8x1_if.sv
// Lane-select bus: eight packed input lanes, a 3-bit select and the registered result.
// The master drives I/SEL and observes Y; the slave (the selector) consumes I/SEL and drives Y.
interface mux_8x1_if #(
    parameter int LANE_W = 1
);
    logic [8*LANE_W-1:0] I;
    logic [2:0]          SEL;
    logic [LANE_W-1:0]   Y;

    modport master (
        output I,
        output SEL,
        input  Y
    );

    modport slave (
        input  I,
        input  SEL,
        output Y
    );
endinterface

// File: rtl/mux_8x1.sv
// Registered 8:1 lane select; one-cycle latency from I/SEL to Y.
// No backpressure: Y reloads on every edge and clears asynchronously on reset.
module mux_8x1 #(
    parameter int LANE_W = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    mux_8x1_if.slave  bus
);

    logic [LANE_W-1:0] lane [8];
    logic [LANE_W-1:0] y_d;
    logic [LANE_W-1:0] y_q;

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            lane[k] = bus.I[k*LANE_W +: LANE_W];
        end
    end

    // Every SEL code maps to exactly one lane, so no hold or default path exists.
    always_comb begin
        y_d = '0;
        y_d = lane[bus.SEL];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign bus.Y = y_q;

endmodule

// File: tb/tb_mux_8x1.sv
// Bench for mux_8x1 at LANE_W=1 and LANE_W=4, checked against a shift-and-mask lane model.
module tb_mux_8x1;

    logic clk;
    logic rst_n;

    int vectors;
    int miscompares;

    mux_8x1_if #(.LANE_W(1)) bus1 ();
    mux_8x1_if #(.LANE_W(4)) bus4 ();

    mux_8x1 #(.LANE_W(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    mux_8x1 #(.LANE_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    // Reference: the selected lane is the input shifted down by SEL lanes, masked to one lane.
    function automatic logic [0:0] model1(input logic [7:0] i, input logic [2:0] s);
        logic [7:0] sh;
        sh = i >> s;
        return sh[0];
    endfunction

    function automatic logic [3:0] model4(input logic [31:0] i, input logic [2:0] s);
        logic [31:0] sh;
        sh = (i >> (4 * int'(s))) & 32'hF;
        return sh[3:0];
    endfunction

    task automatic test_reset();
        rst_n    = 1'b0;
        bus1.I   = 8'hFF;
        bus1.SEL = 3'd7;
        bus4.I   = 32'hFFFF_FFFF;
        bus4.SEL = 3'd7;
        #1;
        for (int n = 0; n < 4; n++) begin
            vectors++;
            if (bus1.Y !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold1 cycle %0d: Y=%b expected 0", n, bus1.Y);
            end
            vectors++;
            if (bus4.Y !== 4'h0) begin
                miscompares++;
                $display("FAIL reset_hold4 cycle %0d: Y=%h expected 0", n, bus4.Y);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (bus1.Y !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release: Y=%b expected 1", bus1.Y);
        end
    endtask

    task automatic test_single_hot();
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            bus1.I   = 8'b0000_0001;
            bus1.SEL = 3'(s);
            @(posedge clk);
            #1;
            vectors++;
            if (bus1.Y !== ((s == 0) ? 1'b1 : 1'b0)) begin
                miscompares++;
                $display("FAIL single_hot sel=%0d: Y=%b expected %b", s, bus1.Y, (s == 0));
            end
        end
    endtask

    task automatic test_pattern();
        logic exp_seq [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            bus1.I   = 8'hA5;
            bus1.SEL = 3'(s);
            @(posedge clk);
            #1;
            vectors++;
            if (bus1.Y !== exp_seq[s]) begin
                miscompares++;
                $display("FAIL pattern_a5 sel=%0d: Y=%b expected %b", s, bus1.Y, exp_seq[s]);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [0:0] exp;
        for (int i = 0; i < 256; i++) begin
            for (int s = 0; s < 8; s++) begin
                @(negedge clk);
                bus1.I   = 8'(i);
                bus1.SEL = 3'(s);
                exp      = model1(8'(i), 3'(s));
                @(posedge clk);
                #1;
                vectors++;
                if (bus1.Y !== exp) begin
                    miscompares++;
                    $display("FAIL exhaustive I=%h sel=%0d: Y=%b expected %b", i, s, bus1.Y, exp);
                end
            end
        end
    endtask

    task automatic test_midcycle_async();
        @(negedge clk);
        bus1.I   = 8'h80;
        bus1.SEL = 3'd7;
        @(posedge clk);
        #1;
        vectors++;
        if (bus1.Y !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_load: Y=%b expected 1", bus1.Y);
        end
        @(negedge clk);
        bus1.SEL = 3'd0;
        #2;
        vectors++;
        if (bus1.Y !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_hold: Y=%b expected 1 before edge", bus1.Y);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (bus1.Y !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_update: Y=%b expected 0", bus1.Y);
        end
        // Reload a 1, then pulse reset between edges.
        @(negedge clk);
        bus1.SEL = 3'd7;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus1.Y !== 1'b0) begin
            miscompares++;
            $display("FAIL async_clear: Y=%b expected 0", bus1.Y);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (bus1.Y !== 1'b0) begin
            miscompares++;
            $display("FAIL async_stay: Y=%b expected 0 after release before edge", bus1.Y);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (bus1.Y !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reload: Y=%b expected 1", bus1.Y);
        end
    endtask

    task automatic test_param();
        @(negedge clk);
        bus4.I   = 32'h7654_3210;
        bus4.SEL = 3'd5;
        @(posedge clk);
        #1;
        vectors++;
        if (bus4.Y !== 4'h5) begin
            miscompares++;
            $display("FAIL param_sel5: Y=%h expected 5", bus4.Y);
        end
        @(negedge clk);
        bus4.SEL = 3'd0;
        @(posedge clk);
        #1;
        vectors++;
        if (bus4.Y !== 4'h0) begin
            miscompares++;
            $display("FAIL param_sel0: Y=%h expected 0", bus4.Y);
        end
    endtask

    task automatic test_random();
        logic [0:0] exp1;
        logic [3:0] exp4;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            bus1.I   = 8'($urandom);
            bus1.SEL = 3'($urandom_range(0, 7));
            bus4.I   = $urandom;
            bus4.SEL = 3'($urandom_range(0, 7));
            exp1     = model1(bus1.I, bus1.SEL);
            exp4     = model4(bus4.I, bus4.SEL);
            @(posedge clk);
            #1;
            vectors++;
            if (bus1.Y !== exp1) begin
                miscompares++;
                $display("FAIL random1 n=%0d: Y=%b expected %b", n, bus1.Y, exp1);
            end
            vectors++;
            if (bus4.Y !== exp4) begin
                miscompares++;
                $display("FAIL random4 n=%0d: Y=%h expected %h", n, bus4.Y, exp4);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single_hot();
        test_pattern();
        test_exhaustive();
        test_midcycle_async();
        test_param();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
